bayer_pattern_gen: RTL and testbench

Synthetic raw-Bayer pixel source. It drives the same pixel stream the greyscale stage consumes: 12-bit data, 11-bit X/Y counters and a data-valid strobe. Its purpose is to exercise the greyscale/line-buffer path on the bench and on the board without the camera sensor attached. It sits in place of the sensor capture block, feeding the greyscale input directly, and adds frame/line framing and a frame counter.

---
 rtl/bayer_pattern_gen.sv | 199 +++++++++++++++++++
 tb/tb_bayer_pattern_gen.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bayer_pattern_gen.sv
// Synthetic raw-Bayer pixel source with frame/line framing and a completed-frame counter.
// Define BAYER_PATTERN_GEN_LFSR_EN to replace the mode-3 checkerboard with LFSR noise.
module bayer_pattern_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_BLANK  = 64,
    parameter int V_ACTIVE = 960,
    parameter int V_BLANK  = 16,
    parameter int FCNT_W   = 16
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iSTART,
    input  logic              iSTOP,
    input  logic [1:0]        iMODE,
    output logic [11:0]       oDATA,
    output logic [10:0]       oX_Cont,
    output logic [10:0]       oY_Cont,
    output logic              oDVAL,
    output logic              oFVAL,
    output logic              oLVAL,
    output logic              oBUSY,
    output logic [FCNT_W-1:0] oFrame_Cont
);

    localparam int VB_LEN = V_BLANK * (H_ACTIVE + H_BLANK);
    localparam int CNT_W  = $clog2(VB_LEN + 1);

    localparam logic [CNT_W-1:0] VB_LAST  = CNT_W'(VB_LEN - 1);
    localparam logic [CNT_W-1:0] HA_LAST  = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] HB_LAST  = CNT_W'(H_BLANK - 1);
    localparam logic [10:0]      ROW_LAST = 11'(V_ACTIVE - 1);

    typedef enum logic [1:0] {IDLE, VBLANK, ACTIVE, HBLANK} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [10:0]        row_q, row_d;
    logic [1:0]         mode_q, mode_d;
    logic               stop_q, stop_d;
    logic [FCNT_W-1:0]  frame_q, frame_d;

    logic [11:0]        data_q, data_d;
    logic [10:0]        xOut_q, xOut_d;
    logic [10:0]        yOut_q, yOut_d;
    logic               dval_q, fval_q, busy_q;
    logic [10:0]        xNext;
    logic               inFrame;

`ifdef BAYER_PATTERN_GEN_LFSR_EN
    localparam logic [11:0] LFSR_SEED = 12'hACE;
    logic [11:0] lfsr_q, lfsr_d;
`endif

    // A single counter times every state; the row register survives only through ACTIVE/HBLANK.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        mode_d  = mode_q;
        stop_d  = stop_q;
        frame_d = frame_q;

        if (state_q != IDLE && iSTOP) begin
            stop_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (iSTART) begin
                    state_d = VBLANK;
                    cnt_d   = '0;
                    row_d   = '0;
                    mode_d  = iMODE;
                end
            end
            VBLANK: begin
                if (cnt_q == VB_LAST) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                    row_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ACTIVE: begin
                if (cnt_q == HA_LAST) begin
                    state_d = HBLANK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HBLANK: begin
                if (cnt_q == HB_LAST) begin
                    cnt_d = '0;
                    if (row_q != ROW_LAST) begin
                        row_d   = row_q + 1'b1;
                        state_d = ACTIVE;
                    end else begin
                        frame_d = frame_q + 1'b1;
                        row_d   = '0;
                        // A stop pulse landing on the final blanking cycle still counts.
                        if (stop_q || iSTOP) begin
                            state_d = IDLE;
                            stop_d  = 1'b0;
                        end else begin
                            state_d = VBLANK;
                            mode_d  = iMODE;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are derived from next-state values so they line up with the state they describe.
    always_comb begin
        xNext   = 11'(cnt_d);
        inFrame = (state_d == ACTIVE) || (state_d == HBLANK);
        xOut_d  = (state_d == ACTIVE) ? xNext : 11'd0;
        yOut_d  = inFrame ? row_d : 11'd0;
        data_d  = 12'h000;
`ifdef BAYER_PATTERN_GEN_LFSR_EN
        lfsr_d  = lfsr_q;
        if (state_d == VBLANK && state_q != VBLANK) begin
            lfsr_d = LFSR_SEED;
        end else if (state_d == ACTIVE) begin
            lfsr_d = {lfsr_q[10:0], lfsr_q[11] ^ lfsr_q[5] ^ lfsr_q[3] ^ lfsr_q[0]};
        end
`endif
        if (state_d == ACTIVE) begin
            unique case (mode_d)
                2'd0: begin
                    unique case ({row_d[0], xNext[0]})
                        2'b00:   data_d = 12'hC00;
                        2'b11:   data_d = 12'h400;
                        default: data_d = 12'h800;
                    endcase
                end
                2'd1: data_d = {xNext, 1'b0};
                2'd2: data_d = {row_d, 1'b0};
`ifdef BAYER_PATTERN_GEN_LFSR_EN
                default: data_d = lfsr_q;
`else
                default: data_d = (xNext[3] ^ row_d[3]) ? 12'hFFF : 12'h000;
`endif
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
            mode_q  <= '0;
            stop_q  <= 1'b0;
            frame_q <= '0;
            data_q  <= '0;
            xOut_q  <= '0;
            yOut_q  <= '0;
            dval_q  <= 1'b0;
            fval_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef BAYER_PATTERN_GEN_LFSR_EN
            lfsr_q  <= LFSR_SEED;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            mode_q  <= mode_d;
            stop_q  <= stop_d;
            frame_q <= frame_d;
            data_q  <= data_d;
            xOut_q  <= xOut_d;
            yOut_q  <= yOut_d;
            dval_q  <= (state_d == ACTIVE);
            fval_q  <= inFrame;
            busy_q  <= (state_d != IDLE);
`ifdef BAYER_PATTERN_GEN_LFSR_EN
            lfsr_q  <= lfsr_d;
`endif
        end
    end

    assign oDATA       = data_q;
    assign oX_Cont     = xOut_q;
    assign oY_Cont     = yOut_q;
    assign oDVAL       = dval_q;
    assign oLVAL       = dval_q;
    assign oFVAL       = fval_q;
    assign oBUSY       = busy_q;
    assign oFrame_Cont = frame_q;

endmodule

// File: tb/tb_bayer_pattern_gen.sv
// Directed bench for bayer_pattern_gen with an 8x4 active window, 2-cycle HBLANK and 1 VBLANK line.
module tb_bayer_pattern_gen;

    localparam int H_ACTIVE = 8;
    localparam int H_BLANK  = 2;
    localparam int V_ACTIVE = 4;
    localparam int V_BLANK  = 1;
    localparam int FCNT_W   = 16;
    localparam int LINE     = H_ACTIVE + H_BLANK;
    localparam int VB_LEN   = V_BLANK * LINE;
    localparam int FRAME    = VB_LEN + V_ACTIVE * LINE;

    logic              clk;
    logic              rstN;
    logic              start;
    logic              stop;
    logic [1:0]        mode;
    logic [11:0]       data;
    logic [10:0]       xCont;
    logic [10:0]       yCont;
    logic              dval;
    logic              fval;
    logic              lval;
    logic              busy;
    logic [FCNT_W-1:0] frameCont;

    int passCount  = 0;
    int checkCount = 0;
    int nDval;
    int nFval;

    bayer_pattern_gen #(
        .H_ACTIVE(H_ACTIVE),
        .H_BLANK (H_BLANK),
        .V_ACTIVE(V_ACTIVE),
        .V_BLANK (V_BLANK),
        .FCNT_W  (FCNT_W)
    ) dut (
        .iCLK       (clk),
        .iRST       (rstN),
        .iSTART     (start),
        .iSTOP      (stop),
        .iMODE      (mode),
        .oDATA      (data),
        .oX_Cont    (xCont),
        .oY_Cont    (yCont),
        .oDVAL      (dval),
        .oFVAL      (fval),
        .oLVAL      (lval),
        .oBUSY      (busy),
        .oFrame_Cont(frameCont)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    function automatic int expPattern(input int m, input int x, input int y);
        case (m)
            0:       return ((y % 2) == 0) ? (((x % 2) == 0) ? 'hC00 : 'h800)
                                           : (((x % 2) == 0) ? 'h800 : 'h400);
            1:       return x * 2;
            2:       return y * 2;
            default: return ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 'hFFF : 'h000;
        endcase
    endfunction

    task automatic checkIdle(input string tag, input int fc);
        checkOutput({tag, " data"}, int'(data), 0);
        checkOutput({tag, " x"}, int'(xCont), 0);
        checkOutput({tag, " y"}, int'(yCont), 0);
        checkOutput({tag, " dval"}, int'(dval), 0);
        checkOutput({tag, " fval"}, int'(fval), 0);
        checkOutput({tag, " lval"}, int'(lval), 0);
        checkOutput({tag, " busy"}, int'(busy), 0);
        checkOutput({tag, " fcnt"}, int'(frameCont), fc);
    endtask

    // Position p = 0 is the edge that enters VBLANK; inputs driven after position p are sampled at p+1.
    task automatic runFrame(input int m, input int fc, input int firstP, input int lastP,
                            input int modeP, input int modeNew, input int stopP1, input int stopP2,
                            input int startLowP, output int dvalSeen, output int fvalSeen);
        int lfsr = 'hACE;
        dvalSeen = 0;
        fvalSeen = 0;
        for (int p = firstP; p <= lastP; p++) begin
            int q    = p - VB_LEN;
            int row  = q / LINE;
            int col  = q % LINE;
            bit act  = (p >= VB_LEN);
            bit line = act && (col < H_ACTIVE);
            int expData;
            string tag;
            applyStimulus();
            tag     = $sformatf("m%0d f%0d p%0d", m, fc, p);
            expData = line ? expPattern(m, col, row) : 0;
`ifdef BAYER_PATTERN_GEN_LFSR_EN
            if (line && m == 3) expData = lfsr;
            if (line) lfsr = ((lfsr << 1) & 'hFFE) |
                             (((lfsr >> 11) ^ (lfsr >> 5) ^ (lfsr >> 3) ^ lfsr) & 1);
`endif
            checkOutput({tag, " data"}, int'(data), expData);
            checkOutput({tag, " x"}, int'(xCont), line ? col : 0);
            checkOutput({tag, " y"}, int'(yCont), act ? row : 0);
            checkOutput({tag, " dval"}, int'(dval), int'(line));
            checkOutput({tag, " lval"}, int'(lval), int'(line));
            checkOutput({tag, " fval"}, int'(fval), int'(act));
            checkOutput({tag, " busy"}, int'(busy), 1);
            checkOutput({tag, " fcnt"}, int'(frameCont), fc);
            dvalSeen += int'(dval);
            fvalSeen += int'(fval);
            if (p == modeP) mode = 2'(modeNew);
            stop = (p == stopP1) || (p == stopP2);
            if (p == startLowP) start = 1'b0;
        end
    endtask

    initial begin
        rstN  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        mode  = 2'd0;
        #3;
        checkIdle("reset", 0);
        applyStimulus();
        applyStimulus();
        rstN = 1'b1;
        applyStimulus();
        checkIdle("idle no start", 0);

        // Frame A: horizontal ramp; switching to mode 0 mid-frame must wait for the frame boundary.
        start = 1'b1;
        mode  = 2'd1;
        runFrame(1, 0, 0, FRAME - 1, 25, 0, -1, -1, -1, nDval, nFval);

        // Frame B: Bayer flat field with pixel and frame-valid counts.
        runFrame(0, 1, 0, FRAME - 1, 30, 2, -1, -1, -1, nDval, nFval);
        checkOutput("dval cycles per frame", nDval, V_ACTIVE * H_ACTIVE);
        checkOutput("fval cycles per frame", nFval, V_ACTIVE * LINE);

        // Frame C: vertical ramp despite mode 3 requested mid-frame.
        runFrame(2, 2, 0, FRAME - 1, 25, 3, -1, -1, -1, nDval, nFval);

        // Frame D: mode 3, two stop pulses, start dropped before the frame ends.
        runFrame(3, 3, 0, FRAME - 1, -1, 0, 22, 35, 40, nDval, nFval);
        applyStimulus();
        checkIdle("after stop", 4);
        for (int i = 0; i < 10; i++) begin
            applyStimulus();
            checkOutput($sformatf("stopped dval %0d", i), int'(dval), 0);
            checkOutput($sformatf("stopped busy %0d", i), int'(busy), 0);
        end

        // Frame E: stop pulse coincident with the end-of-frame cycle, start held high.
        start = 1'b1;
        mode  = 2'd1;
        runFrame(1, 4, 0, FRAME - 1, -1, 0, FRAME - 1, -1, -1, nDval, nFval);
        applyStimulus();
        stop = 1'b0;
        checkIdle("eof stop", 5);

        // Frame F: restarts after one IDLE cycle, then reset lands in ACTIVE row 2.
        runFrame(1, 5, 0, VB_LEN + 2 * LINE + 3, -1, 0, -1, -1, -1, nDval, nFval);
        #2;
        rstN = 1'b0;
        #1;
        checkIdle("async reset", 0);
        mode = 2'd2;
        applyStimulus();
        rstN = 1'b1;
        runFrame(2, 0, 0, FRAME - 1, -1, 0, -1, -1, -1, nDval, nFval);
        applyStimulus();
        checkOutput("fcnt after fresh frame", int'(frameCont), 1);
        checkOutput("busy continuous", int'(busy), 1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
